// File: rtl/level_encode.sv
// rtl/level_encode.sv - CAVLC level encoder: trailing-one signs plus adaptive level_prefix/level_suffix codewords
// Define LEVEL_ENC_STATS_EN to add the BitCount output (bits emitted in the current block).
module level_encode #(
    parameter int LEVEL_W        = 13,
    parameter int MAX_SUFFIX_LEN = 6
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Start,
    input  logic [4:0]         TotalCoeff,
    input  logic [1:0]         TrailingOnes,
    input  logic [LEVEL_W-1:0] LevelIn,
    input  logic               InValid,
    output logic               InReady,
    output logic [27:0]        CodeBits,
    output logic [4:0]         CodeLen,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Done,
    output logic               Err
`ifdef LEVEL_ENC_STATS_EN
    ,
    output logic [9:0]         BitCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_LEVEL,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] MAX_S = 3'(MAX_SUFFIX_LEN);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_tc;
    logic [4:0]  r_cnt;
    logic [1:0]  r_t1;
    logic [2:0]  r_suffix;
    logic [27:0] r_code_bits;
    logic [4:0]  r_code_len;
    logic        r_out_valid;
    logic        r_err;

    logic             w_start;
    logic             w_accept;
    logic             w_neg;
    logic             w_first;
    logic             w_ovf;
    logic [LEVEL_W:0] w_lvl_x;
    logic [LEVEL_W:0] w_abs;
    logic [LEVEL_W:0] w_thr;
    logic [14:0]      w_lc_raw;
    logic [14:0]      w_lc;
    logic [14:0]      w_base;
    logic [14:0]      w_diff;
    logic [3:0]       w_prefix;
    logic [3:0]       w_nbits;
    logic [11:0]      w_suffix;
    logic [2:0]       w_s1;
    logic [2:0]       w_s_next;
    logic [27:0]      w_code;
    logic [4:0]       w_len;

    assign w_start  = Start && (r_state == S_IDLE);
    assign InReady  = ((r_state == S_T1) || (r_state == S_LEVEL)) && (!r_out_valid || OutReady);
    assign w_accept = InValid && InReady;

    assign w_neg    = LevelIn[LEVEL_W-1];
    assign w_lvl_x  = {w_neg, LevelIn};
    assign w_abs    = w_neg ? ((~w_lvl_x) + (LEVEL_W+1)'(1)) : w_lvl_x;
    assign w_lc_raw = 15'({w_abs, 1'b0}) - (w_neg ? 15'd1 : 15'd2);

    // With fewer than three trailing ones the first remaining level cannot be +-1, so its code space shifts down by 2
    assign w_first  = (r_state == S_LEVEL) && (r_cnt == {3'b000, r_t1}) && (r_t1 != 2'd3);
    assign w_lc     = (w_first && (w_lc_raw >= 15'd2)) ? (w_lc_raw - 15'd2) : w_lc_raw;

    always_comb begin
        w_prefix = 4'd0;
        w_nbits  = 4'd0;
        w_suffix = 12'd0;
        w_diff   = 15'd0;
        w_ovf    = 1'b0;
        w_base   = 15'd15 << r_suffix;
        if ((r_suffix == 3'd0) && (w_lc < 15'd14)) begin
            w_prefix = w_lc[3:0];
        end else if ((r_suffix == 3'd0) && (w_lc < 15'd30)) begin
            w_prefix = 4'd14;
            w_nbits  = 4'd4;
            w_suffix = 12'(w_lc - 15'd14);
        end else if ((r_suffix != 3'd0) && (w_lc < w_base)) begin
            w_prefix = 4'(w_lc >> r_suffix);
            w_nbits  = {1'b0, r_suffix};
            w_suffix = 12'(w_lc & ((15'd1 << r_suffix) - 15'd1));
        end else begin
            w_prefix = 4'd15;
            w_nbits  = 4'd12;
            w_diff   = w_lc - ((r_suffix == 3'd0) ? 15'd30 : w_base);
            if (w_diff > 15'd4095) begin
                w_suffix = 12'hFFF;
                w_ovf    = 1'b1;
            end else begin
                w_suffix = w_diff[11:0];
            end
        end
    end

    // Prefix zeros contribute nothing to the value; only the marker bit and suffix are set
    always_comb begin
        w_code = 28'd0;
        w_len  = 5'd0;
        if (r_state == S_T1) begin
            w_code = {27'd0, w_neg};
            w_len  = 5'd1;
        end else begin
            w_code = (28'd1 << w_nbits) | {16'd0, w_suffix};
            w_len  = {1'b0, w_prefix} + {1'b0, w_nbits} + 5'd1;
        end
    end

    assign w_s1     = (r_suffix == 3'd0) ? 3'd1 : r_suffix;
    assign w_thr    = (LEVEL_W+1)'(3) << (w_s1 - 3'd1);
    assign w_s_next = ((w_abs > w_thr) && (w_s1 < MAX_S)) ? (w_s1 + 3'd1) : w_s1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (TotalCoeff == 5'd0) begin
                        w_next = S_DONE;
                    end else if (TrailingOnes != 2'd0) begin
                        w_next = S_T1;
                    end else begin
                        w_next = S_LEVEL;
                    end
                end
            end
            S_T1: begin
                if (w_accept && ((r_cnt + 5'd1) == {3'b000, r_t1})) begin
                    w_next = (r_tc == {3'b000, r_t1}) ? S_DRAIN : S_LEVEL;
                end
            end
            S_LEVEL: begin
                if (w_accept && ((r_cnt + 5'd1) == r_tc)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_out_valid || OutReady) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_tc        <= 5'd0;
            r_t1        <= 2'd0;
            r_cnt       <= 5'd0;
            r_suffix    <= 3'd0;
            r_code_bits <= 28'd0;
            r_code_len  <= 5'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_start) begin
                r_tc     <= TotalCoeff;
                r_t1     <= TrailingOnes;
                r_cnt    <= 5'd0;
                r_suffix <= ((TotalCoeff > 5'd10) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
                r_err    <= 1'b0;
            end
            if (w_accept) begin
                r_cnt       <= r_cnt + 5'd1;
                r_code_bits <= w_code;
                r_code_len  <= w_len;
                r_out_valid <= 1'b1;
                if (r_state == S_LEVEL) begin
                    r_suffix <= w_s_next;
                    if (w_ovf) begin
                        r_err <= 1'b1;
                    end
                end
            end else if (OutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef LEVEL_ENC_STATS_EN
    logic [9:0] r_bit_count;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_bit_count <= 10'd0;
        end else if (w_start) begin
            r_bit_count <= 10'd0;
        end else if (r_out_valid && OutReady) begin
            r_bit_count <= r_bit_count + {5'd0, r_code_len};
        end
    end

    assign BitCount = r_bit_count;
`endif

    assign CodeBits = r_code_bits;
    assign CodeLen  = r_code_len;
    assign OutValid = r_out_valid;
    assign Done     = (r_state == S_DONE);
    assign Err      = r_err;

endmodule

// File: tb/tb_level_encode.sv
// tb/tb_level_encode.sv - table-driven bench for level_encode with backpressure and reset sequences
module tb_level_encode;

    logic        Clk          = 1'b0;
    logic        nReset       = 1'b0;
    logic        Start        = 1'b0;
    logic [4:0]  TotalCoeff   = 5'd0;
    logic [1:0]  TrailingOnes = 2'd0;
    logic [12:0] LevelIn      = 13'd0;
    logic        InValid      = 1'b0;
    logic        InReady;
    logic [27:0] CodeBits;
    logic [4:0]  CodeLen;
    logic        OutValid;
    logic        OutReady     = 1'b1;
    logic        Done;
    logic        Err;
`ifdef LEVEL_ENC_STATS_EN
    logic [9:0]  BitCount;
`endif

    int n_pass  = 0;
    int n_total = 0;

    level_encode #(.LEVEL_W(13), .MAX_SUFFIX_LEN(6)) dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .Start        (Start),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .LevelIn      (LevelIn),
        .InValid      (InValid),
        .InReady      (InReady),
        .CodeBits     (CodeBits),
        .CodeLen      (CodeLen),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Done         (Done),
        .Err          (Err)
`ifdef LEVEL_ENC_STATS_EN
        ,
        .BitCount     (BitCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int                 tc;
        int                 t1;
        bit                 err;
        logic [15:0][12:0]  lvl;
        logic [15:0][27:0]  code;
        logic [15:0][4:0]   len;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nv(input int tc, input int t1, input bit err);
        cur.tc   = tc;
        cur.t1   = t1;
        cur.err  = err;
        cur.lvl  = '0;
        cur.code = '0;
        cur.len  = '0;
    endtask

    task automatic lv(input int i, input int l, input int c, input int n);
        cur.lvl[i]  = 13'(l);
        cur.code[i] = 28'(c);
        cur.len[i]  = 5'(n);
    endtask

    task automatic start_block(input int tc, input int t1);
        Start        = 1'b1;
        TotalCoeff   = 5'(tc);
        TrailingOnes = 2'(t1);
        @(posedge Clk); #1;
        Start        = 1'b0;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int n_in;
        int n_out;
        int last_out;
        int bits;
        bit done_seen;
        n_in      = 0;
        n_out     = 0;
        last_out  = -1;
        bits      = 0;
        done_seen = 1'b0;
        OutReady  = 1'b1;
        start_block(v.tc, v.t1);
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (OutValid) begin
                if (n_out < v.tc) begin
                    chk($sformatf("v%0d_code%0d", vi, n_out), 32'(CodeBits), 32'(v.code[n_out]));
                    chk($sformatf("v%0d_len%0d", vi, n_out), 32'(CodeLen), 32'(v.len[n_out]));
                    bits = bits + int'(v.len[n_out]);
                end
                n_out++;
                last_out = cyc;
            end
            if (Done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d_done_cycle", vi), 32'(cyc), 32'(last_out + 1));
                chk($sformatf("v%0d_n_out", vi), 32'(n_out), 32'(v.tc));
                chk($sformatf("v%0d_err", vi), 32'(Err), 32'(v.err));
`ifdef LEVEL_ENC_STATS_EN
                chk($sformatf("v%0d_bitcount", vi), 32'(BitCount), 32'(bits));
`endif
            end
            if (n_in < v.tc) begin
                InValid = 1'b1;
                LevelIn = v.lvl[n_in];
            end else begin
                InValid = 1'b0;
            end
            #1;
            if (InValid && InReady) n_in++;
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), 32'(done_seen), 32'd1);
        chk($sformatf("v%0d_done_pulse", vi), 32'(Done), 32'd0);
        chk($sformatf("v%0d_idle_ov", vi), 32'(OutValid), 32'd0);
        chk($sformatf("v%0d_err_hold", vi), 32'(Err), 32'(v.err));
    endtask

    initial begin
        nv(1, 1, 0); lv(0, -1, 1, 1); vecs.push_back(cur);
        nv(2, 0, 0); lv(0, 2, 1, 1); lv(1, -3, 'h3, 4); vecs.push_back(cur);
        nv(3, 3, 0); lv(0, 1, 0, 1); lv(1, -1, 1, 1); lv(2, 1, 0, 1); vecs.push_back(cur);
        nv(4, 3, 0); lv(0, 1, 0, 1); lv(1, 1, 0, 1); lv(2, 1, 0, 1); lv(3, 16, 'h1000, 28); vecs.push_back(cur);
        nv(4, 3, 0); lv(0, 1, 0, 1); lv(1, 1, 0, 1); lv(2, 1, 0, 1); lv(3, 8, 'h10, 19); vecs.push_back(cur);
        nv(4, 3, 0); lv(0, 1, 0, 1); lv(1, 1, 0, 1); lv(2, 1, 0, 1); lv(3, -7, 'h1, 14); vecs.push_back(cur);
        nv(4, 3, 0); lv(0, 1, 0, 1); lv(1, 1, 0, 1); lv(2, 1, 0, 1); lv(3, -15, 'h1F, 19); vecs.push_back(cur);
        nv(1, 0, 1); lv(0, -4096, 'h1FFF, 28); vecs.push_back(cur);
        nv(0, 0, 0); vecs.push_back(cur);
        nv(2, 1, 0); lv(0, -1, 1, 1); lv(1, 3, 1, 3); vecs.push_back(cur);
        nv(3, 0, 0); lv(0, 5, 1, 7); lv(1, -7, 'h5, 6); lv(2, 100, 'h104E, 28); vecs.push_back(cur);
        nv(7, 0, 0);
        lv(0, 200, 'h116E, 28); lv(1, 200, 'h1152, 28); lv(2, 200, 'h1116, 28); lv(3, 200, 'h109E, 28);
        lv(4, 200, 'h2E, 18); lv(5, 200, 'h4E, 13); lv(6, 200, 'h4E, 13);
        vecs.push_back(cur);
        nv(11, 0, 0); lv(0, 2, 2, 2);
        for (int i = 1; i < 11; i++) lv(i, 2, 2, 3);
        vecs.push_back(cur);
        nv(11, 3, 0);
        for (int i = 0; i < 3; i++) lv(i, 1, 0, 1);
        lv(3, 2, 1, 3);
        for (int i = 4; i < 11; i++) lv(i, 2, 2, 3);
        vecs.push_back(cur);

        nReset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_inready", 32'(InReady), 32'd0);
        chk("rst_codebits", 32'(CodeBits), 32'd0);
        chk("rst_codelen", 32'(CodeLen), 32'd0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        nReset = 1'b1;
        @(posedge Clk); #1;

        for (int vi = 0; vi < vecs.size(); vi++) begin
            run_vec(vi, vecs[vi]);
        end

        // Backpressure: levels +2,-3,+4 -> (1,1),(3,4),(2,5); a Start pulse mid-block must be ignored
        start_block(3, 0);
        OutReady = 1'b1;
        InValid  = 1'b1;
        LevelIn  = 13'(2);
        #1;
        chk("bp_inready_first", 32'(InReady), 32'd1);
        @(posedge Clk); #1;
        LevelIn  = 13'(-3);
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                Start        = 1'b1;
                TotalCoeff   = 5'd0;
                TrailingOnes = 2'd0;
            end else begin
                Start = 1'b0;
            end
            #1;
            chk($sformatf("bp_stall%0d_ov", k), 32'(OutValid), 32'd1);
            chk($sformatf("bp_stall%0d_code", k), 32'(CodeBits), 32'd1);
            chk($sformatf("bp_stall%0d_len", k), 32'(CodeLen), 32'd1);
            chk($sformatf("bp_stall%0d_inready", k), 32'(InReady), 32'd0);
            @(posedge Clk); #1;
        end
        Start    = 1'b0;
        OutReady = 1'b1;
        #1;
        chk("bp_inready_resume", 32'(InReady), 32'd1);
        @(posedge Clk); #1;
        chk("bp_l2_ov", 32'(OutValid), 32'd1);
        chk("bp_l2_code", 32'(CodeBits), 32'd3);
        chk("bp_l2_len", 32'(CodeLen), 32'd4);
        LevelIn = 13'(4);
        @(posedge Clk); #1;
        InValid = 1'b0;
        chk("bp_l3_code", 32'(CodeBits), 32'd2);
        chk("bp_l3_len", 32'(CodeLen), 32'd5);
        @(posedge Clk); #1;
        chk("bp_done", 32'(Done), 32'd1);
        chk("bp_done_ov", 32'(OutValid), 32'd0);
        @(posedge Clk); #1;

        // Reset in the middle of a block drops the pending codeword
        start_block(2, 0);
        InValid = 1'b1;
        LevelIn = 13'(2);
        @(posedge Clk); #1;
        InValid = 1'b0;
        chk("mid_pre_ov", 32'(OutValid), 32'd1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(OutValid), 32'd0);
        chk("mid_rst_code", 32'(CodeBits), 32'd0);
        chk("mid_rst_len", 32'(CodeLen), 32'd0);
        chk("mid_rst_inready", 32'(InReady), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        @(posedge Clk); #1;
        nReset = 1'b1;
        @(posedge Clk); #1;
        run_vec(100, vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
